// File: rtl/sobel_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sobel_pkg : shared types and constants for the Sobel user-logic chain
// Revision  : 1.0
// ---------------------------------------------------------------------------
package sobel_pkg;

   localparam int PIX_W          = 8;
   localparam int DEF_IMG_WIDTH  = 512;
   localparam int DEF_IMG_HEIGHT = 512;

   // Vertical 3-pixel column: p1 = row r-2, p2 = row r-1, p3 = row r.
   typedef struct packed {
      logic [PIX_W-1:0] p1;
      logic [PIX_W-1:0] p2;
      logic [PIX_W-1:0] p3;
   } sobel_col_t;

endpackage
`default_nettype wire

// File: rtl/sobel_line_buffer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sobel_line_buffer_if : pixel-in / column-out valid-ack streams
// Revision             : 1.0
// ---------------------------------------------------------------------------
interface sobel_line_buffer_if;
   import sobel_pkg::*;

   logic [PIX_W-1:0] i_pixel;
   logic             i_pixel_valid;
   logic             o_pixel_ack;
   logic [PIX_W-1:0] o_pixel_1;
   logic [PIX_W-1:0] o_pixel_2;
   logic [PIX_W-1:0] o_pixel_3;
   logic             o_pixel_valid;
   logic             i_pixel_ack;

   modport slave (
      input  i_pixel, i_pixel_valid, i_pixel_ack,
      output o_pixel_ack, o_pixel_1, o_pixel_2, o_pixel_3, o_pixel_valid
   );

   modport master (
      output i_pixel, i_pixel_valid, i_pixel_ack,
      input  o_pixel_ack, o_pixel_1, o_pixel_2, o_pixel_3, o_pixel_valid
   );

endinterface
`default_nettype wire

// File: rtl/sobel_line_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sobel_line_ram : single-port line memory, async read, sync write
// Revision       : 1.0
// ---------------------------------------------------------------------------
module sobel_line_ram
   import sobel_pkg::*;
#(
   parameter int DEPTH  = DEF_IMG_WIDTH,
   parameter int ADDR_W = 9
) (
   input  wire logic              i_clk,
   input  wire logic              i_we,
   input  wire logic [ADDR_W-1:0] i_addr,
   input  wire logic [PIX_W-1:0]  i_wdata,
   output logic      [PIX_W-1:0]  o_rdata
);

   logic [PIX_W-1:0] mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/sobel_line_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sobel_line_buffer : two-line buffer emitting vertical 3-pixel columns
// Revision          : 1.0
// ---------------------------------------------------------------------------
module sobel_line_buffer
   import sobel_pkg::*;
#(
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter int COL_W      = 9,
   parameter int ROW_W      = 9
) (
   input  wire logic          i_clk,
   input  wire logic          i_rst,
   sobel_line_buffer_if.slave bus,
   output logic               o_primed
);

   localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [ROW_W-1:0] PRIME_ROW = ROW_W'(2);

   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic             valid_q, valid_d;
   logic             primed_q, primed_d;
   sobel_col_t       data_q, data_d;

   logic             accept;
   logic [PIX_W-1:0] rd_a;
   logic [PIX_W-1:0] rd_b;

   assign bus.o_pixel_ack = ~valid_q | bus.i_pixel_ack;
   assign accept          = bus.i_pixel_valid & bus.o_pixel_ack;

   // mem_a holds row r-1; on each accept its old word shifts into mem_b (row r-2).
   sobel_line_ram #(.DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_mem_a (
      .i_clk   (i_clk),
      .i_we    (accept),
      .i_addr  (col_q),
      .i_wdata (bus.i_pixel),
      .o_rdata (rd_a)
   );

   sobel_line_ram #(.DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_mem_b (
      .i_clk   (i_clk),
      .i_we    (accept),
      .i_addr  (col_q),
      .i_wdata (rd_a),
      .o_rdata (rd_b)
   );

   always_comb begin
      col_d   = col_q;
      row_d   = row_q;
      valid_d = valid_q;
      data_d  = data_q;
      if (bus.i_pixel_ack) begin
         valid_d = 1'b0;
      end
      if (accept) begin
         col_d = (col_q == LAST_COL) ? '0 : col_q + COL_W'(1);
         if (col_q == LAST_COL) begin
            row_d = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
         end
         // A primed accept overrides the drain so the stream runs at full rate.
         if (row_q >= PRIME_ROW) begin
            data_d  = '{p1: rd_b, p2: rd_a, p3: bus.i_pixel};
            valid_d = 1'b1;
         end
      end
      primed_d = (row_d >= PRIME_ROW);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         col_q    <= '0;
         row_q    <= '0;
         valid_q  <= 1'b0;
         primed_q <= 1'b0;
         data_q   <= '0;
      end else begin
         col_q    <= col_d;
         row_q    <= row_d;
         valid_q  <= valid_d;
         primed_q <= primed_d;
         data_q   <= data_d;
      end
   end

   assign bus.o_pixel_1     = data_q.p1;
   assign bus.o_pixel_2     = data_q.p2;
   assign bus.o_pixel_3     = data_q.p3;
   assign bus.o_pixel_valid = valid_q;
   assign o_primed          = primed_q;

endmodule
`default_nettype wire
